// File: rtl/fetch_issue_nox_if.sv
// rtl/fetch_issue_nox_if.sv - fetch FIFO / issue stage bundle
// Ports (names seen from the issue stage):
//   fifo_empty_i, fifo_data_i         FIFO head word and empty flag
//   fifo_read_o, fifo_clear_o         FIFO pop and clear strobes
//   jump_i, jump_pc_i, fetch_pending_i redirect strobe, target, in-flight count
//   instr_valid_o, instr_ready_i      issue handshake to decode
//   instr_o, pc_o, issued_cnt_o       issued word, its PC, transfer counter
// master: the issue stage; slave: FIFO, redirect source and decode.
interface fetch_issue_nox_if #(
   parameter int WIDTH = 32
);
   logic             fifo_empty_i;
   logic [WIDTH-1:0] fifo_data_i;
   logic             fifo_read_o;
   logic             fifo_clear_o;
   logic             jump_i;
   logic [31:0]      jump_pc_i;
   logic [3:0]       fetch_pending_i;
   logic             instr_valid_o;
   logic             instr_ready_i;
   logic [WIDTH-1:0] instr_o;
   logic [31:0]      pc_o;
   logic [31:0]      issued_cnt_o;

   modport master (
      input  fifo_empty_i, fifo_data_i, jump_i, jump_pc_i, fetch_pending_i,
             instr_ready_i,
      output fifo_read_o, fifo_clear_o, instr_valid_o, instr_o, pc_o,
             issued_cnt_o
   );

   modport slave (
      output fifo_empty_i, fifo_data_i, jump_i, jump_pc_i, fetch_pending_i,
             instr_ready_i,
      input  fifo_read_o, fifo_clear_o, instr_valid_o, instr_o, pc_o,
             issued_cnt_o
   );
endinterface

// File: rtl/fetch_issue_nox.sv
// rtl/fetch_issue_nox.sv - instruction issue stage behind the fetch FIFO
// Pops words from the FIFO, tags them with a PC and holds them in a
// registered valid/ready stage for decode. A redirect clears the FIFO and
// drops a given number of stale words still arriving from the bus.
// Ports: clk, rst (async, active-high), bus (fetch_issue_nox_if.master).
module fetch_issue_nox #(
   parameter int          WIDTH    = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   fetch_issue_nox_if.master bus
);

   typedef enum logic {
      ST_RUN,
      ST_DISCARD
   } state_t;

   state_t           state_q, state_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] instr_q, instr_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      pc_ff_q, pc_ff_d;
   logic [3:0]       discard_q, discard_d;
   logic [31:0]      issued_q, issued_d;
   logic             pop;
   logic             transfer;

   // Pop decision. In DISCARD the output stage is empty, so a pop never
   // needs to wait for decode. Gated by rst so the FIFO sees no strobes
   // while the block is held in reset.
   always_comb begin
      transfer = valid_q && bus.instr_ready_i;
      pop      = 1'b0;
      if (!rst && !bus.jump_i && !bus.fifo_empty_i) begin
         if (state_q == ST_DISCARD) begin
            pop = 1'b1;
         end else begin
            pop = !valid_q || bus.instr_ready_i;
         end
      end
   end

   assign bus.fifo_read_o   = pop;
   assign bus.fifo_clear_o  = bus.jump_i && !rst;
   assign bus.instr_valid_o = valid_q;
   assign bus.instr_o       = instr_q;
   assign bus.pc_o          = pc_q;
   assign bus.issued_cnt_o  = issued_q;

   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      instr_d   = instr_q;
      pc_d      = pc_q;
      pc_ff_d   = pc_ff_q;
      discard_d = discard_q;
      // A transfer in the jump cycle was already accepted by decode.
      issued_d  = issued_q + 32'(transfer);

      if (bus.jump_i) begin
         valid_d   = 1'b0;
         pc_ff_d   = {bus.jump_pc_i[31:2], 2'b00};
         discard_d = bus.fetch_pending_i;
         state_d   = (bus.fetch_pending_i != 4'd0) ? ST_DISCARD : ST_RUN;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (pop) begin
                  instr_d = bus.fifo_data_i;
                  pc_d    = pc_ff_q;
                  valid_d = 1'b1;
                  pc_ff_d = pc_ff_q + 32'd4;
               end else if (transfer) begin
                  valid_d = 1'b0;
               end
            end
            ST_DISCARD: begin
               valid_d = 1'b0;
               if (pop) begin
                  discard_d = discard_q - 4'd1;
                  if (discard_q == 4'd1) begin
                     state_d = ST_RUN;
                  end
               end
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_RUN;
         valid_q   <= 1'b0;
         instr_q   <= '0;
         pc_q      <= 32'd0;
         pc_ff_q   <= RESET_PC;
         discard_q <= 4'd0;
         issued_q  <= 32'd0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         instr_q   <= instr_d;
         pc_q      <= pc_d;
         pc_ff_q   <= pc_ff_d;
         discard_q <= discard_d;
         issued_q  <= issued_d;
      end
   end

endmodule
